// File: rtl/progmem_arbiter.sv
// rtl/progmem_arbiter.sv - round-robin arbiter sharing one program memory among several cores
//
// Purpose: grants at most one core fetch per cycle to the single progmem port
// using a rotating priority pointer. Each read is returned to the core that
// issued it, exactly MEM_LAT enabled cycles later, through a shift register of
// one-hot tags.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   en           global enable; 0 freezes the pointer and the tag pipeline
//   core_req     per-core fetch request, held by the core until granted
//   core_addr    per-core fetch address, core i at [i*ADDR_W +: ADDR_W]
//   core_gnt     one-hot grant for this cycle (combinational)
//   core_rvalid  one-hot owner of core_rdata for this cycle
//   core_rdata   progmem read data, broadcast to all cores
//   mem_en       progmem read strobe
//   mem_addr     progmem read address
//   mem_data     progmem read data, valid MEM_LAT cycles after mem_en

`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif
`ifndef INST_W
`define INST_W 32
`endif

module progmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = `INST_ADDR_W,
  parameter int DATA_W    = `INST_W,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]                    ptr_q, ptr_d;
  logic [MEM_LAT-1:0][NUM_CORES-1:0]   tag_q, tag_d;

  logic             active;
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   cand;
  logic [NUM_CORES-1:0] gnt_vec;

  // Rotating-priority scan: candidates are visited in order ptr, ptr+1, ...
  // wrapping modulo NUM_CORES; the first requester seen wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_CORES)) begin
        cand = cand - (PTR_W+1)'(NUM_CORES);
      end
      if (!found && core_req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    active   = en && !rst;
    gnt_vec  = '0;
    mem_en   = 1'b0;
    mem_addr = '0;
    ptr_d    = ptr_q;
    if (active && found) begin
      gnt_vec[win] = 1'b1;
      mem_en       = 1'b1;
      mem_addr     = core_addr[win*ADDR_W +: ADDR_W];
      // Priority moves just past the winner so it becomes lowest next cycle.
      if (win == PTR_W'(NUM_CORES-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win + 1'b1;
      end
    end
  end

  // The tag pipeline advances only with en, in lockstep with the progmem,
  // which is frozen by the same enable; a zero tag fills idle cycles.
  always_comb begin
    tag_d = tag_q;
    if (en) begin
      tag_d[0] = gnt_vec;
      for (int k = 1; k < MEM_LAT; k++) begin
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      tag_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
    end
  end

  assign core_gnt    = gnt_vec;
  assign core_rvalid = active ? tag_q[MEM_LAT-1] : '0;
  assign core_rdata  = mem_data;

endmodule

// File: tb/tb_progmem_arbiter.sv
// tb/tb_progmem_arbiter.sv - scoreboard bench for the progmem arbiter

module tb_progmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [N-1:0]    core_req = '0;
  logic [N*AW-1:0] core_addr = '0;
  logic [N-1:0]    core_gnt;
  logic [N-1:0]    core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;

  progmem_arbiter #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .core_req(core_req), .core_addr(core_addr),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            core;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;   // number of enabled, non-reset clock edges so far
  int   ptr_m  = 0;   // reference priority pointer

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a ^ 8'h3C, ~a};
  endfunction

  // Progmem model: a MEM_LAT-stage read pipeline frozen by en.
  logic [DW-1:0] memp [L];
  always @(posedge clk) begin
    if (en) begin
      memp[0] <= memf(mem_addr);
      for (int k = 1; k < L; k++) memp[k] <= memp[k-1];
    end
  end
  assign mem_data = memp[L-1];

  always @(posedge clk) begin
    if (en && !rst) ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, predict the grant from the round-robin rule, queue the
  // expected return, then check the combinational outputs mid-cycle.
  task automatic step(input logic [N-1:0] req, input logic e, input logic r);
    int w;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    core_req = req;
    en       = e;
    rst      = r;
    for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = AW'($urandom);
    eg = '0;
    ea = '0;
    w  = -1;
    if (r) begin
      ptr_m = 0;
      sbq.delete();
    end else if (e) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      end
      if (w >= 0) begin
        eg[w] = 1'b1;
        ea    = core_addr[w*AW +: AW];
        sbq.push_back('{w, memf(ea), ecnt + L});
        ptr_m = (w + 1) % N;
      end
    end
    @(negedge clk);
    chk("core_gnt", 32'(core_gnt), 32'(eg));
    chk("mem_en",   32'(mem_en),   32'(eg != '0));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
  endtask

  // Monitor: the head of the scoreboard is due once the required number of
  // enabled edges has elapsed and the current cycle is enabled.
  logic [N-1:0]  mon_ev;
  logic [DW-1:0] mon_ed;
  always @(negedge clk) begin
    mon_ev = '0;
    mon_ed = '0;
    if (sbq.size() > 0 && en && !rst && sbq[0].due == ecnt) begin
      mon_ev[sbq[0].core] = 1'b1;
      mon_ed = sbq[0].data;
      void'(sbq.pop_front());
    end
    chk("core_rvalid", 32'(core_rvalid), 32'(mon_ev));
    if (mon_ev != '0 && core_rvalid == mon_ev) begin
      chk("core_rdata", 32'(core_rdata), 32'(mon_ed));
    end
  end

  initial begin
    // Reset held two cycles with every core requesting.
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    // All request: eight consecutive grants rotating 0..3.
    repeat (8) step(4'hF, 1'b1, 1'b0);
    // Wrap and skip: core2 leaves ptr at 3, then 0101 grants core0 then core2.
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    // Enable freeze with a read in flight.
    step(4'b0100, 1'b1, 1'b0);
    repeat (4) step(4'hF, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b1, 1'b0);
    // Reset mid-flight: the core3 read is discarded, priority restarts at 0.
    step(4'b1000, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b0);
    repeat (L + 1) step(4'h0, 1'b1, 1'b0);
    // Randomised traffic with occasional freezes and resets.
    repeat (600) begin
      step(N'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
    end
    repeat (L + 2) step(4'h0, 1'b1, 1'b0);
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
